// File: rtl/aes_byte_scanner_if.sv
// ---------------------------------------------------------------------------
// aes_byte_scanner_if
// Bundles the scanner's data/control inputs and display outputs.
//   data_in   [127:0]  AES result word to be scanned
//   start              single-cycle scan request
//   stop               abort request
//   byte_idx  [3:0]    index of the byte being converted or held
//   bcd       [11:0]   {hundreds, tens, ones} of the held byte
//   bcd_valid          bcd holds a completed conversion
//   busy               scanner is not idle
//   done               one-cycle pulse at the end of a non-looping scan
// master: the block driving start/stop/data_in; slave: the scanner itself.
// ---------------------------------------------------------------------------
interface aes_byte_scanner_if;
  logic [127:0] data_in;
  logic         start;
  logic         stop;
  logic [3:0]   byte_idx;
  logic [11:0]  bcd;
  logic         bcd_valid;
  logic         busy;
  logic         done;

  modport master (
    output data_in, start, stop,
    input  byte_idx, bcd, bcd_valid, busy, done
  );

  modport slave (
    input  data_in, start, stop,
    output byte_idx, bcd, bcd_valid, busy, done
  );
endinterface

// File: rtl/aes_byte_scanner.sv
// ---------------------------------------------------------------------------
// aes_byte_scanner
// Snapshots a 128-bit AES word on start and walks its 16 bytes (byte 0 =
// bits [7:0] first). Each byte is converted to three BCD digits with an
// 8-cycle double-dabble loop and then held on the outputs for DWELL cycles.
// Ports:
//   clk_i    system clock, all state on the rising edge
//   reset_i  synchronous active-high reset
//   bus      aes_byte_scanner_if.slave (data_in/start/stop in, display out)
// Parameters:
//   DWELL    hold time per byte in cycles (0 behaves as 1)
//   LOOP     non-zero: wrap from byte 15 back to byte 0 instead of stopping
// ---------------------------------------------------------------------------
module aes_byte_scanner #(
  parameter int unsigned DWELL = 32'd1000,
  parameter int unsigned LOOP  = 32'd0
) (
  input  logic                clk_i,
  input  logic                reset_i,
  aes_byte_scanner_if.slave   bus
);

  localparam int unsigned    DWELL_EFF  = (DWELL == 32'd0) ? 32'd1 : DWELL;
  localparam int unsigned    DCW        = $clog2(DWELL_EFF + 32'd1);
  localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL_EFF - 32'd1);
  localparam logic [DCW-1:0] DWELL_ONE  = DCW'(32'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e         state_q;
  logic [127:0]   snap_q;
  // Double-dabble working register: {hundreds, tens, ones, remaining binary}.
  logic [19:0]    work_q;
  logic [2:0]     shift_q;
  logic [DCW-1:0] dwell_q;
  logic [3:0]     byte_idx_q;
  logic [11:0]    bcd_q;
  logic           bcd_valid_q;
  logic           busy_q;
  logic           done_q;

  logic [19:0]    work_d;
  logic [3:0]     byte_idx_d;
  logic [7:0]     next_byte_d;

  // Correct a BCD digit before the shift so it cannot exceed 9 afterwards.
  function automatic logic [3:0] add3(input logic [3:0] d);
    if (d >= 4'd5) begin
      return d + 4'd3;
    end else begin
      return d;
    end
  endfunction

  // One double-dabble iteration: correct all digits, then shift in the binary MSB.
  function automatic logic [19:0] dabble_step(input logic [19:0] w);
    logic [19:0] a;
    a = {add3(w[19:16]), add3(w[15:12]), add3(w[11:8]), w[7:0]};
    return {a[18:0], 1'b0};
  endfunction

  // Byte idx of the snapshot, byte 0 being the least significant.
  function automatic logic [7:0] byte_sel(input logic [127:0] s, input logic [3:0] idx);
    return s[{idx, 3'b000} +: 8];
  endfunction

  // Next conversion step and the byte that follows the current one (wraps 15 -> 0).
  always_comb begin
    work_d      = dabble_step(work_q);
    byte_idx_d  = byte_idx_q + 4'd1;
    next_byte_d = byte_sel(snap_q, byte_idx_d);
  end

  // Scanner FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      snap_q      <= 128'd0;
      work_q      <= 20'd0;
      shift_q     <= 3'd0;
      dwell_q     <= '0;
      byte_idx_q  <= 4'd0;
      bcd_q       <= 12'd0;
      bcd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop) begin
        // Abort: byte_idx and bcd deliberately keep their last values.
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        bcd_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              snap_q     <= bus.data_in;
              work_q     <= {12'd0, bus.data_in[7:0]};
              shift_q    <= 3'd0;
              byte_idx_q <= 4'd0;
              busy_q     <= 1'b1;
              state_q    <= CONV;
            end
          end
          CONV: begin
            work_q  <= work_d;
            shift_q <= shift_q + 3'd1;
            if (shift_q == 3'd7) begin
              bcd_q       <= work_d[19:8];
              bcd_valid_q <= 1'b1;
              dwell_q     <= '0;
              state_q     <= HOLD;
            end
          end
          HOLD: begin
            if (dwell_q == DWELL_LAST) begin
              bcd_valid_q <= 1'b0;
              if ((byte_idx_q != 4'd15) || (LOOP != 32'd0)) begin
                byte_idx_q <= byte_idx_d;
                work_q     <= {12'd0, next_byte_d};
                shift_q    <= 3'd0;
                state_q    <= CONV;
              end else begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end else begin
              dwell_q <= dwell_q + DWELL_ONE;
            end
          end
          default: begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            bcd_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.byte_idx  = byte_idx_q;
  assign bus.bcd       = bcd_q;
  assign bus.bcd_valid = bcd_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_aes_byte_scanner.sv
// ---------------------------------------------------------------------------
// tb_aes_byte_scanner
// Three scanners share one stimulus stream: A (DWELL=4, LOOP=0),
// B (DWELL=4, LOOP=1) and C (DWELL=0, LOOP=0). After every edge each one is
// compared with a timeline model that derives the expected outputs from the
// number of edges since start, using decimal arithmetic for the BCD value.
// ---------------------------------------------------------------------------
module tb_aes_byte_scanner;

  logic         clk = 1'b0;
  logic         reset_r = 1'b1;
  logic         start_r = 1'b0;
  logic         stop_r = 1'b0;
  logic [127:0] data_r = 128'd0;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [127:0] REF_WORD = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;

  aes_byte_scanner_if ifa ();
  aes_byte_scanner_if ifb ();
  aes_byte_scanner_if ifc ();

  assign ifa.data_in = data_r;
  assign ifa.start   = start_r;
  assign ifa.stop    = stop_r;
  assign ifb.data_in = data_r;
  assign ifb.start   = start_r;
  assign ifb.stop    = stop_r;
  assign ifc.data_in = data_r;
  assign ifc.start   = start_r;
  assign ifc.stop    = stop_r;

  aes_byte_scanner #(.DWELL(32'd4), .LOOP(32'd0)) dut_a (.clk_i(clk), .reset_i(reset_r), .bus(ifa));
  aes_byte_scanner #(.DWELL(32'd4), .LOOP(32'd1)) dut_b (.clk_i(clk), .reset_i(reset_r), .bus(ifb));
  aes_byte_scanner #(.DWELL(32'd0), .LOOP(32'd0)) dut_c (.clk_i(clk), .reset_i(reset_r), .bus(ifc));

  // {busy, done, bcd_valid, byte_idx, bcd}
  logic [18:0] act [3];
  assign act[0] = {ifa.busy, ifa.done, ifa.bcd_valid, ifa.byte_idx, ifa.bcd};
  assign act[1] = {ifb.busy, ifb.done, ifb.bcd_valid, ifb.byte_idx, ifb.bcd};
  assign act[2] = {ifc.busy, ifc.done, ifc.bcd_valid, ifc.byte_idx, ifc.bcd};

  // Reference model state per DUT.
  logic         m_active [3];
  logic         m_done   [3];
  logic         m_valid  [3];
  int           m_idx    [3];
  int           m_k      [3];
  logic [11:0]  m_bcd    [3];
  logic [127:0] m_snap   [3];

  function automatic int dwell_of(input int i);
    case (i)
      0:       return 4;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic bit loop_of(input int i);
    return (i == 1);
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (reset_r) begin
        m_active[i] = 1'b0; m_done[i] = 1'b0; m_valid[i] = 1'b0;
        m_idx[i] = 0; m_k[i] = 0; m_bcd[i] = 12'd0; m_snap[i] = 128'd0;
      end else if (stop_r) begin
        m_active[i] = 1'b0; m_done[i] = 1'b0; m_valid[i] = 1'b0;
      end else if (!m_active[i]) begin
        m_done[i] = 1'b0; m_valid[i] = 1'b0;
        if (start_r) begin
          m_active[i] = 1'b1; m_k[i] = 0; m_idx[i] = 0; m_snap[i] = data_r;
        end
      end else begin
        int p;
        int b;
        int r;
        p = dwell_of(i) + 8;
        m_k[i]++;
        b = m_k[i] / p;
        r = m_k[i] % p;
        if (b >= 16 && !loop_of(i)) begin
          m_active[i] = 1'b0; m_done[i] = 1'b1; m_valid[i] = 1'b0;
        end else begin
          m_done[i]  = 1'b0;
          m_idx[i]   = b % 16;
          m_valid[i] = (r >= 8);
          if (r >= 8) m_bcd[i] = to_bcd(int'(m_snap[i][m_idx[i]*8 +: 8]));
        end
      end
    end
  endtask

  task automatic check_all();
    logic [18:0] exp;
    for (int i = 0; i < 3; i++) begin
      exp = {m_active[i], m_done[i], m_valid[i], 4'(m_idx[i]), m_bcd[i]};
      check($sformatf("model_dut%0d", i), 32'(act[i]), 32'(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset_r = 1'b1; start_r = 1'b0; stop_r = 1'b0;
    tick();
    tick();
    reset_r = 1'b0;
  endtask

  task automatic pulse_start();
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  b;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl [10];
  int   c;

  initial begin
    tbl[0] = '{8'd0,   12'h000};
    tbl[1] = '{8'd255, 12'h255};
    tbl[2] = '{8'd9,   12'h009};
    tbl[3] = '{8'd10,  12'h010};
    tbl[4] = '{8'd99,  12'h099};
    tbl[5] = '{8'd100, 12'h100};
    tbl[6] = '{8'hAA,  12'h170};
    tbl[7] = '{8'hBB,  12'h187};
    tbl[8] = '{8'hEE,  12'h238};
    tbl[9] = '{8'hCD,  12'h205};
    for (int i = 0; i < 3; i++) begin
      m_active[i] = 1'b0; m_done[i] = 1'b0; m_valid[i] = 1'b0;
      m_idx[i] = 0; m_k[i] = 0; m_bcd[i] = 12'd0; m_snap[i] = 128'd0;
    end

    // Reset state.
    do_reset();
    check("reset_zero_a", 32'(act[0]), 32'd0);
    check("reset_zero_c", 32'(act[2]), 32'd0);

    // Table of single bytes with hand-computed BCD.
    for (int j = 0; j < 10; j++) begin
      do_reset();
      data_r = {120'd0, tbl[j].b};
      pulse_start();
      repeat (8) tick();
      check("table_bcd_c", 32'(ifc.bcd), 32'(tbl[j].exp));
      check("table_bcd_a", 32'(ifa.bcd), 32'(tbl[j].exp));
      check("table_valid_c", 32'(ifc.bcd_valid), 32'd1);
    end

    // Full scan of the reference word; data changes after the snapshot and
    // a start during HOLD must both be ignored.
    do_reset();
    data_r = REF_WORD;
    pulse_start();
    data_r = {128{1'b1}};
    c = 0;
    while (c < 400) begin
      c++;
      start_r = (c == 10);
      tick();
      if (c == 8) begin
        check("first_bcd", 32'(ifa.bcd), 32'h255);
        check("first_valid", 32'(ifa.bcd_valid), 32'd1);
      end
      if (c == 20) check("second_bcd", 32'(ifa.bcd), 32'h238);
      if (ifa.done) break;
    end
    start_r = 1'b0;
    check("done_cycle", c, 32'd192);
    check("last_bcd", 32'(ifa.bcd), 32'h000);
    repeat (8) tick();
    check("busy_after_done", 32'(ifa.busy), 32'd0);
    check("loop_wrap_idx", 32'(ifb.byte_idx), 32'd0);
    check("loop_wrap_bcd", 32'(ifb.bcd), 32'h255);
    check("loop_wrap_valid", 32'(ifb.bcd_valid), 32'd1);

    // Stop during CONV of byte 3, then start+stop together, then restart.
    do_reset();
    data_r = REF_WORD;
    pulse_start();
    repeat (39) tick();
    stop_r = 1'b1;
    tick();
    stop_r = 1'b0;
    check("stop_busy", 32'(ifa.busy), 32'd0);
    check("stop_valid", 32'(ifa.bcd_valid), 32'd0);
    check("stop_done", 32'(ifa.done), 32'd0);
    check("stop_idx", 32'(ifa.byte_idx), 32'd3);
    start_r = 1'b1; stop_r = 1'b1;
    tick();
    start_r = 1'b0; stop_r = 1'b0;
    check("start_stop_busy", 32'(ifa.busy), 32'd0);
    pulse_start();
    check("restart_idx", 32'(ifa.byte_idx), 32'd0);
    repeat (8) tick();
    check("restart_bcd", 32'(ifa.bcd), 32'h255);

    // Reset during HOLD of byte 7, then start from scratch.
    do_reset();
    data_r = REF_WORD;
    pulse_start();
    repeat (93) tick();
    reset_r = 1'b1;
    tick();
    check("midscan_reset_zero", 32'(act[0]), 32'd0);
    tick();
    reset_r = 1'b0;
    pulse_start();
    repeat (7) tick();
    check("post_reset_not_yet", 32'(ifa.bcd_valid), 32'd0);
    tick();
    check("post_reset_valid", 32'(ifa.bcd_valid), 32'd1);
    check("post_reset_idx", 32'(ifa.byte_idx), 32'd0);

    // Exhaustive byte sweep: 16 scans cover 0x00..0xFF.
    for (int s = 0; s < 16; s++) begin
      do_reset();
      for (int j = 0; j < 16; j++) data_r[j*8 +: 8] = 8'(16 * s + j);
      pulse_start();
      repeat (16 * 9) tick();
      check("sweep_done_c", 32'(ifc.done), 32'd1);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      data_r  = {$urandom, $urandom, $urandom, $urandom};
      start_r = ($urandom_range(0, 29) == 0);
      stop_r  = ($urandom_range(0, 599) == 0);
      reset_r = ($urandom_range(0, 1499) == 0);
      tick();
    end
    reset_r = 1'b0; start_r = 1'b0; stop_r = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_byte_scanner.md
AES_BYTE_SCANNER -- requirements
Module: aes_byte_scanner

Interface
REQ-001 Parameter DWELL, default 1000: number of clk cycles each converted byte is held on the outputs; a value of 0 SHALL be treated as 1.
REQ-002 Parameter LOOP, default 0: when 1, the scan restarts at byte 0 after byte 15 instead of stopping.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_in  input  128  AES result word (plaintext, ciphertext or decrypted text) from the AES top-level selector.
REQ-006 start  input  1  single-cycle request to snapshot data_in and begin a scan.
REQ-007 stop  input  1  abort request; returns the block to IDLE.
REQ-008 byte_idx  output  4  index of the byte currently being converted or held.
REQ-009 bcd  output  12  BCD of the held byte: [11:8] hundreds, [7:4] tens, [3:0] ones; feeds the three segment7 decoders.
REQ-010 bcd_valid  output  1  high while bcd holds a completed conversion.
REQ-011 busy  output  1  high in every state other than IDLE.
REQ-012 done  output  1  one-cycle pulse when a non-looping scan completes.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CONV and HOLD.
REQ-014 IDLE with start=1 and stop=0 at an edge: capture data_in into the internal snapshot, set byte_idx=0, clear the shift counter, go to CONV.
REQ-015 Byte i SHALL be snapshot bits [8i+7:8i], so byte 0 is bits [7:0].
REQ-016 CONV SHALL perform one shift-and-add-3 (double-dabble) iteration per cycle, 8 iterations per byte, MSB first.
REQ-017 On the 8th CONV edge: load the completed result into bcd, set bcd_valid=1, clear the dwell counter, go to HOLD.
REQ-018 bcd_valid SHALL rise exactly 8 cycles after the edge that sampled start.
REQ-019 HOLD SHALL last exactly DWELL cycles, with bcd and byte_idx stable throughout.
REQ-020 On the last HOLD edge with byte_idx<15: increment byte_idx, clear bcd_valid, go to CONV. bcd SHALL keep its last value while bcd_valid=0.
REQ-021 On the last HOLD edge with byte_idx=15:
- LOOP=1: set byte_idx=0 (wrap-around), clear bcd_valid, go to CONV, reusing the same snapshot.
- LOOP=0: clear bcd_valid, assert done for one cycle, go to IDLE.
REQ-022 Each byte period SHALL be DWELL+8 cycles; a full non-looping scan SHALL be 16*(DWELL+8) cycles from the start edge to the done pulse.
REQ-023 stop=1 in any state: go to IDLE at that edge and clear bcd_valid; done SHALL NOT assert; byte_idx and bcd keep their values.
REQ-024 start while busy SHALL be ignored; the snapshot SHALL NOT change during a scan.
REQ-025 start and stop both high at the same edge: stop wins, and the block stays in or returns to IDLE.
REQ-026 Changes on data_in after the snapshot SHALL have no effect on the outputs.
REQ-027 Converting 255 SHALL give 0x255; every BCD digit SHALL stay in the range 0-9.

Reset
REQ-028 reset=1 at an edge SHALL override start and stop and force: state=IDLE, byte_idx=0, bcd=0, bcd_valid=0, busy=0, done=0, snapshot=0, all counters=0.
REQ-029 reset asserted in the middle of CONV or HOLD SHALL abort the scan with no done pulse; the first start after reset release SHALL behave as from power-up.

Verification
REQ-030 DWELL=4, LOOP=0, data_in=0x00112233445566778899aabbccddeeff, pulse start: byte 0 bcd=0x255 valid 8 cycles after start; byte 1 bcd=0x238; byte 15 bcd=0x000; done pulse at cycle 192; busy then low.
REQ-031 DWELL=4, LOOP=1, same data: after byte 15, byte_idx wraps to 0 and bcd=0x255 appears again 12 cycles after byte 15's HOLD began; done is never asserted.
REQ-032 Change data_in to all-ones one cycle after start: all 16 held values still match the original snapshot; a start pulse during HOLD is ignored.
REQ-033 stop during CONV of byte 3: next cycle busy=0, bcd_valid=0, done=0, byte_idx=3; a new start restarts at byte 0.
REQ-034 reset in HOLD of byte 7, then start after release: outputs are zero during reset, and the scan restarts with byte_idx=0 and first bcd valid 8 cycles after start.
REQ-035 Exhaustive byte sweep: data_in bytes 0x00..0xFF across 16 scans; each bcd matches the decimal value of its byte, and DWELL=0 gives a 1-cycle hold.
